// File: rtl/instr_sequencer.sv
// instr_sequencer
//
// Multi-cycle instruction sequencer. It holds the program counter, the
// instruction register and the retired-instruction counter. It fetches over a
// req/ready handshake and steps each instruction through decode, execute,
// memory and write-back. The external combinational decoder sees opcode and
// aluop, and the ctl_* bits it returns choose the path through the FSM.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   imem_req/addr     instruction fetch request and word address (= pc)
//   imem_ready/rdata  fetch completion and fetched instruction word
//   opcode, aluop     IR fields driven to the control decoder
//   ctl_*             decoded control bits from the decoder
//   branch_target     branch destination from the datapath
//   dmem_req/we/ready data-memory request, write qualifier, completion
//   rf_we             register-file write strobe (one-cycle pulse in WB)
//   halted            illegal opcode seen, core stopped until reset
//   retired           retired-instruction counter (wraps)
//   state             current FSM state encoding, for debug
//
// state  | meaning
// -------+------------------------------------------------------------
// RST    | reset, leaves for FETCH on the first edge after rst_n rises
// FETCH  | imem_req high, waits for imem_ready, loads IR
// DECODE | one cycle, rejects illegal opcodes
// EXEC   | samples ctl_* in priority branch > mem > rwrite > plain ALU
// MEM    | dmem_req high until dmem_ready
// WB     | rf_we pulse, then advance pc
// HALT   | halted high, terminal until reset

module instr_sequencer #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [4:0]         opcode,
    output logic [2:0]         aluop,
    input  logic               ctl_we,
    input  logic               ctl_selmem,
    input  logic               ctl_rwrite,
    input  logic               ctl_branch,
    input  logic [PC_W-1:0]    branch_target,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ready,
    output logic               rf_we,
    output logic               halted,
    output logic [15:0]        retired,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [4:0]      OP_MAX = 5'b00100;
    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t             st;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
    logic               ir_unused;

    assign imem_addr = pc;
    assign opcode    = ir[INSTR_W-1 -: 5];
    assign aluop     = ir[INSTR_W-6 -: 3];
    assign state     = st;
    // Write qualifier tracks the decoder directly while the request is up.
    assign dmem_we   = dmem_req & ctl_we;
    // Low IR bits belong to the datapath (register specifiers, immediates).
    assign ir_unused = ^ir[INSTR_W-9:0];

    // Strobes are registered from the next state, so each one is high exactly
    // while the FSM sits in the state that owns it. The async reset clears
    // them together with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= ST_RST;
            pc       <= '0;
            ir       <= '0;
            retired  <= '0;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            rf_we    <= 1'b0;
            halted   <= 1'b0;
        end else begin
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            rf_we    <= 1'b0;
            halted   <= 1'b0;
            case (st)
                ST_RST: begin
                    st       <= ST_FETCH;
                    imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        ir <= imem_rdata;
                        st <= ST_DECODE;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (ir[INSTR_W-1 -: 5] > OP_MAX) begin
                        st     <= ST_HALT;
                        halted <= 1'b1;
                    end else begin
                        st <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (ctl_branch) begin
                        pc       <= branch_target;
                        retired  <= retired + 16'd1;
                        st       <= ST_FETCH;
                        imem_req <= 1'b1;
                    end else if (ctl_we | ctl_selmem) begin
                        st       <= ST_MEM;
                        dmem_req <= 1'b1;
                    end else if (ctl_rwrite) begin
                        st    <= ST_WB;
                        rf_we <= 1'b1;
                    end else begin
                        pc       <= pc + PC_ONE;
                        retired  <= retired + 16'd1;
                        st       <= ST_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        if (ctl_selmem & ctl_rwrite) begin
                            st    <= ST_WB;
                            rf_we <= 1'b1;
                        end else begin
                            pc       <= pc + PC_ONE;
                            retired  <= retired + 16'd1;
                            st       <= ST_FETCH;
                            imem_req <= 1'b1;
                        end
                    end else begin
                        dmem_req <= 1'b1;
                    end
                end
                ST_WB: begin
                    pc       <= pc + PC_ONE;
                    retired  <= retired + 16'd1;
                    st       <= ST_FETCH;
                    imem_req <= 1'b1;
                end
                ST_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    st <= ST_RST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [4:0]  opcode;
    logic [2:0]  aluop;
    logic        ctl_we, ctl_selmem, ctl_rwrite, ctl_branch;
    logic [15:0] branch_target;
    logic        dmem_req, dmem_we, dmem_ready;
    logic        rf_we, halted;
    logic [15:0] retired;
    logic [2:0]  state;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .opcode       (opcode),
        .aluop        (aluop),
        .ctl_we       (ctl_we),
        .ctl_selmem   (ctl_selmem),
        .ctl_rwrite   (ctl_rwrite),
        .ctl_branch   (ctl_branch),
        .branch_target(branch_target),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .rf_we        (rf_we),
        .halted       (halted),
        .retired      (retired),
        .state        (state)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] exp_pc;
    logic [15:0] exp_ret;
    logic [4:0]  last_op;

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  alu;
        logic        we, sm, rw, br;
        logic [15:0] tgt;
        int          iw, dw;
        int          e_cyc, e_rf, e_mem;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Instruction-level timing model: cycles from the first FETCH cycle to the
    // next FETCH (or to the first HALT cycle), plus strobe occupancy.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int fetch = v.iw + 1;
        r.e_rf  = 0;
        r.e_mem = 0;
        if (v.op > 5'd4)        r.e_cyc = fetch + 1;
        else if (v.br)          r.e_cyc = fetch + 2;
        else if (v.we || v.sm) begin
            r.e_mem = v.dw + 1;
            r.e_rf  = (v.sm && v.rw) ? 1 : 0;
            r.e_cyc = fetch + 2 + r.e_mem + r.e_rf;
        end else if (v.rw) begin
            r.e_rf  = 1;
            r.e_cyc = fetch + 3;
        end else                r.e_cyc = fetch + 2;
        return r;
    endfunction

    // Called with the DUT sampled in FETCH; returns with it sampled in the
    // next FETCH (or in HALT for an illegal opcode).
    task automatic run_instr(input vec_t v, input string tag);
        int cyc = 0, nf = 0, nm = 0, nr = 0;
        bit fetched = 0, op_chk = 0, done = 0;
        bit addr_bad = 0, we_bad = 0, ir_bad = 0;
        bit exp_halt;
        exp_halt      = (v.op > 5'd4);
        ctl_we        = v.we;
        ctl_selmem    = v.sm;
        ctl_rwrite    = v.rw;
        ctl_branch    = v.br;
        branch_target = v.tgt;
        imem_rdata    = {v.op, v.alu, 24'($urandom)};
        for (int i = 0; i < 100; i++) begin
            if (fetched && (imem_req || halted)) begin
                done = 1;
                break;
            end
            cyc++;
            if (fetched && !op_chk) begin
                chk({tag, " opcode"}, opcode, v.op);
                chk({tag, " aluop"}, aluop, v.alu);
                op_chk = 1;
            end
            if (imem_req) begin
                nf++;
                if (imem_addr !== exp_pc) addr_bad = 1;
                if (opcode !== last_op) ir_bad = 1;
                imem_ready = (nf > v.iw);
                if (imem_ready) fetched = 1;
            end else begin
                imem_ready = 1'($urandom);
            end
            if (dmem_req) begin
                nm++;
                if (dmem_we !== v.we) we_bad = 1;
                dmem_ready = (nm > v.dw);
            end else begin
                dmem_ready = 1'($urandom);
            end
            if (rf_we) nr++;
            step;
        end
        chk({tag, " finished"}, done, 1);
        chk({tag, " cycles"}, cyc, v.e_cyc);
        chk({tag, " rf_we_cycles"}, nr, v.e_rf);
        chk({tag, " dmem_req_cycles"}, nm, v.e_mem);
        chk({tag, " fetch_addr_stable"}, addr_bad, 0);
        chk({tag, " ir_held_in_fetch"}, ir_bad, 0);
        chk({tag, " dmem_we"}, we_bad, 0);
        chk({tag, " halted"}, halted, exp_halt);
        if (!exp_halt) begin
            exp_pc  = v.br ? v.tgt : exp_pc + 16'd1;
            exp_ret = exp_ret + 16'd1;
            chk({tag, " next_pc"}, imem_addr, exp_pc);
        end
        chk({tag, " retired"}, retired, exp_ret);
        last_op = v.op;
    endtask

    task automatic go_reset;
        rst_n = 1'b0;
        #1;
        step;
        rst_n   = 1'b1;
        exp_pc  = '0;
        exp_ret = '0;
        last_op = '0;
        step;
    endtask

    initial begin
        vec_t v;
        bit bad;

        //           op  alu we sm rw br tgt       iw dw cyc rf mem
        tbl[0]  = '{5'd0, 3'd1, 0, 0, 1, 0, 16'h0000, 0, 0, 4, 1, 0};
        tbl[1]  = '{5'd1, 3'd2, 0, 0, 0, 1, 16'h0040, 0, 0, 3, 0, 0};
        tbl[2]  = '{5'd2, 3'd0, 1, 0, 0, 0, 16'h0000, 0, 2, 6, 0, 3};
        tbl[3]  = '{5'd3, 3'd3, 0, 1, 1, 0, 16'h0000, 0, 0, 5, 1, 1};
        tbl[4]  = '{5'd0, 3'd4, 0, 0, 1, 0, 16'h0000, 3, 0, 7, 1, 0};
        tbl[5]  = '{5'd1, 3'd5, 0, 0, 0, 0, 16'h0000, 0, 0, 3, 0, 0};
        tbl[6]  = '{5'd2, 3'd6, 0, 1, 0, 0, 16'h0000, 1, 1, 6, 0, 2};
        tbl[7]  = '{5'd4, 3'd7, 0, 0, 1, 1, 16'hFFFF, 0, 0, 3, 0, 0};
        tbl[8]  = '{5'd0, 3'd0, 0, 0, 0, 0, 16'h0000, 0, 0, 3, 0, 0};
        tbl[9]  = '{5'd2, 3'd1, 1, 0, 1, 0, 16'h0000, 0, 0, 4, 0, 1};
        tbl[10] = '{5'd4, 3'd2, 0, 0, 1, 0, 16'h0000, 0, 0, 4, 1, 0};
        tbl[11] = '{5'd3, 3'd0, 1, 1, 1, 0, 16'h0000, 2, 1, 8, 1, 2};

        rst_n = 1'b0;
        imem_ready = 0; imem_rdata = '0; dmem_ready = 0;
        ctl_we = 0; ctl_selmem = 0; ctl_rwrite = 0; ctl_branch = 0;
        branch_target = '0;
        exp_pc = '0; exp_ret = '0; last_op = '0;

        step;
        step;
        chk("reset state", state, 3'd0);
        chk("reset imem_req", imem_req, 0);
        chk("reset dmem_req", dmem_req, 0);
        chk("reset dmem_we", dmem_we, 0);
        chk("reset rf_we", rf_we, 0);
        chk("reset halted", halted, 0);
        chk("reset retired", retired, 0);
        chk("reset imem_addr", imem_addr, 0);
        rst_n = 1'b1;
        step;
        chk("first fetch state", state, 3'd1);
        chk("first fetch imem_req", imem_req, 1);
        chk("first fetch addr", imem_addr, 0);

        for (int i = 0; i < 12; i++) run_instr(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 150; i++) begin
            v.op  = 5'($urandom_range(0, 4));
            v.alu = 3'($urandom);
            v.we  = 1'($urandom);
            v.sm  = 1'($urandom);
            v.rw  = 1'($urandom);
            v.br  = ($urandom_range(0, 3) == 0);
            v.tgt = 16'($urandom);
            v.iw  = $urandom_range(0, 2);
            v.dw  = $urandom_range(0, 2);
            v = model(v);
            run_instr(v, $sformatf("rnd%0d", i));
        end

        // Reset while a store is waiting on dmem_ready.
        ctl_we = 1; ctl_selmem = 0; ctl_rwrite = 0; ctl_branch = 0;
        imem_rdata = {5'd2, 3'd0, 24'd0};
        imem_ready = 1; dmem_ready = 0;
        step;
        imem_ready = 0;
        step;
        step;
        chk("midrst dmem_req before", dmem_req, 1);
        step;
        chk("midrst dmem_we waiting", dmem_we, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst dmem_req dropped", dmem_req, 0);
        chk("midrst dmem_we dropped", dmem_we, 0);
        chk("midrst state", state, 3'd0);
        ctl_we = 0;
        go_reset;
        chk("midrst refetch addr", imem_addr, 0);
        chk("midrst retired", retired, 0);
        chk("midrst imem_req", imem_req, 1);

        // Illegal opcode: halts, stays silent, and only reset recovers.
        v = '{5'd5, 3'd0, 0, 0, 1, 0, 16'h0000, 1, 0, 0, 0, 0};
        v = model(v);
        run_instr(v, "illegal");
        bad = 0;
        for (int i = 0; i < 22; i++) begin
            imem_ready = 1'($urandom);
            dmem_ready = 1'($urandom);
            if (imem_req !== 1'b0 || dmem_req !== 1'b0 || halted !== 1'b1) bad = 1;
            step;
        end
        chk("halt held silent", bad, 0);
        chk("halt state", state, 3'd6);
        rst_n = 1'b0;
        #1;
        chk("halt cleared by reset", halted, 0);
        imem_ready = 0; dmem_ready = 0;
        go_reset;
        chk("post-halt fetch addr", imem_addr, 0);
        chk("post-halt imem_req", imem_req, 1);
        run_instr(tbl[0], "post-halt alu");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer for the processor core. It owns the program counter and instruction register, and fetches instructions over a ready/req handshake. It presents the opcode and ALU-op fields to the combinational control decoder, and steps each instruction through decode, execute, memory and write-back. Decoded control bits come back from the decoder and choose the path through the state machine. The block also gates the register-file write and data-memory strobes.

## Interface
- PC_W, 16, program-counter and memory address width (word addressed)
- INSTR_W, 32, instruction width; opcode = IR[INSTR_W-1 -: 5], aluop = IR[INSTR_W-6 -: 3]
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ready  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  INSTR_W  fetched instruction
- opcode  out  5  IR opcode field, to decoder
- aluop  out  3  IR ALU-op field, to decoder
- ctl_we  in  1  decoded data-memory write
- ctl_selmem  in  1  decoded data-memory read
- ctl_rwrite  in  1  decoded register-file write
- ctl_branch  in  1  decoded branch
- branch_target  in  PC_W  branch destination from datapath
- dmem_req  out  1  data-memory request
- dmem_we  out  1  data-memory write qualifier (valid with dmem_req)
- dmem_ready  in  1  data access complete
- rf_we  out  1  register-file write strobe (one-cycle pulse)
- halted  out  1  illegal opcode seen; core stopped
- retired  out  16  retired-instruction counter
- state  out  3  current state encoding, for debug

## Operation
- States and encodings: RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Reset (async, rst_n=0):
  - state=RST, pc=0, IR=0, retired=0.
  - All strobes (imem_req, dmem_req, dmem_we, rf_we, halted) are 0.
  - While rst_n is low the block stays in RST. On the first clock edge after rst_n rises, RST -> FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ready=1: IR<=imem_rdata, go to DECODE.
  - Otherwise stay in FETCH with req and addr held stable.
- DECODE:
  - One cycle.
  - If opcode > 5'b00100 (illegal), go to HALT. Otherwise go to EXEC.
- EXEC: one cycle; control inputs sampled in priority order.
  - ctl_branch: pc<=branch_target, retired+1, go to FETCH.
  - else ctl_we | ctl_selmem: go to MEM.
  - else ctl_rwrite: go to WB.
  - else: pc<=pc+1, retired+1, go to FETCH.
- MEM:
  - dmem_req=1 and dmem_we=ctl_we, held until dmem_ready=1.
  - On dmem_ready: if ctl_selmem & ctl_rwrite, go to WB. Otherwise pc<=pc+1, retired+1, go to FETCH.
- WB: rf_we=1 for exactly one cycle, pc<=pc+1, retired+1, go to FETCH.
- HALT:
  - halted=1; no requests are issued.
  - Terminal: only reset leaves HALT.
- Arithmetic and wrap:
  - pc+1 wraps modulo 2^PC_W (all-ones -> 0).
  - retired wraps modulo 2^16.
- Handshake inputs:
  - imem_ready is ignored outside FETCH.
  - dmem_ready is ignored outside MEM.
  - A ready arriving in the same cycle as req rises completes the transfer (zero-wait).
- opcode and aluop are driven continuously from IR. IR changes only on fetch completion, so the decoder outputs are stable from DECODE through WB.
- Outputs are Moore (decoded from state), except dmem_we, which follows ctl_we in MEM.

## Timing
- Cycle counts with zero-wait memories, counted from the FETCH cycle:
  - ALU/register instruction: FETCH, DECODE, EXEC, WB = 4 cycles.
  - Non-writing ALU instruction: 3 cycles.
  - Branch: 3 cycles; the new imem_addr appears in the 4th cycle.
  - Store: 4 cycles.
  - Load with write-back: 5 cycles.
- Each wait cycle on imem_ready or dmem_ready adds exactly one cycle.
- A reset asserted mid-operation (any state, including a pending handshake) drops every strobe immediately (combinationally from state=RST). The in-flight transfer is abandoned.

## Test plan
- ALU instruction, opcode=00000 aluop=001, readies tied high:
  - Required: imem_addr=0 in cycle 1, rf_we=1 in cycle 4 only.
  - After retirement: pc=1, retired=1.
- Fetch stall, imem_ready low for 3 cycles:
  - Required: imem_req=1 for 4 cycles with imem_addr constant.
  - IR/opcode change only on the ready cycle.
- Branch, ctl_branch=1, branch_target=0x0040:
  - Next imem_addr=0x0040.
  - No rf_we and no dmem_req.
  - retired increments by 1.
- Store, ctl_we=1, dmem_ready after 2 wait cycles:
  - dmem_req=dmem_we=1 for 3 cycles.
  - Then FETCH at pc+1, with no rf_we.
- Illegal opcode 5'b00101:
  - halted=1 starting the cycle after DECODE.
  - imem_req stays 0 for 20+ cycles.
  - rst_n pulse clears halted and the next fetch uses pc=0.
- PC wrap: branch to 0xFFFF, then a non-branch instruction; the next fetch address is 0x0000.
- Reset mid-access: assert rst_n=0 during a MEM wait; dmem_req falls in the same cycle.
